// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the single-bus CPU control sequencer:
//               opcode codes (which are also the ALU function codes),
//               sequencer state encoding, step constants T0-T7, instruction
//               classes and the strobe bundle produced by the step decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int STEP_W = 3;
    localparam int OP_W   = 5;

    // Opcodes, IR[31:27]. The same codes drive alu_op.
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Step constants
    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;
    localparam logic [STEP_W-1:0] T5 = 3'd5;
    localparam logic [STEP_W-1:0] T6 = 3'd6;
    localparam logic [STEP_W-1:0] T7 = 3'd7;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R  = 4'd0,
        CLS_ALU_I  = 4'd1,
        CLS_UNARY  = 4'd2,
        CLS_LD     = 4'd3,
        CLS_LDI    = 4'd4,
        CLS_ST     = 4'd5,
        CLS_MULDIV = 4'd6,
        CLS_BR     = 4'd7,
        CLS_JR     = 4'd8,
        CLS_IO_IN  = 4'd9,
        CLS_IO_OUT = 4'd10,
        CLS_MFX    = 4'd11,
        CLS_NOP    = 4'd12,
        CLS_HALT   = 4'd13
    } instr_class_t;

    // Strobes common to every build. Zhighout and HIin exist only with the
    // multiply/divide option and are handled separately in the top level.
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic const_out;
        logic ba_out;
        logic r_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic lo_in;
        logic outport_in;
        logic con_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } strobes_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Control-unit <-> datapath bundle. IR, CON_FF and Stop flow
//               into the sequencer; every bus-drive, register-load,
//               register-select and memory strobe plus alu_op and Run flow
//               out to the datapath.
//   master : control unit (drives strobes, reads IR/CON_FF/Stop)
//   slave  : datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if;
    import cpu_pkg::*;

    logic [31:0]     IR;
    logic            CON_FF;
    logic            Stop;

    logic            PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic            InPortout, Cout, BAout, Rout;
    logic            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic            OutPortin, CONin, Rin;
    logic            Gra, Grb, Grc;
    logic            IncPC, Read, Write;
    logic [OP_W-1:0] alu_op;
    logic            Run;

    modport master (
        input  IR, CON_FF, Stop,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output InPortout, Cout, BAout, Rout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
        output OutPortin, CONin, Rin,
        output Gra, Grb, Grc,
        output IncPC, Read, Write, alu_op, Run
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  InPortout, Cout, BAout, Rout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
        input  OutPortin, CONin, Rin,
        input  Gra, Grb, Grc,
        input  IncPC, Read, Write, alu_op, Run
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode classifier. Maps the 5-bit opcode to an
//               instruction class and the index of its last step.
//   i_op        : opcode (IR[31:27])
//   o_cls       : instruction class
//   o_last_step : last step of the instruction (T2..T7)
// Build option: CTRL_MULDIV_EN - when undefined, mul/div classify as nop.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    output instr_class_t      o_cls,
    output logic [STEP_W-1:0] o_last_step
);

    always_comb begin
        // Undefined opcodes fall through to nop.
        o_cls       = CLS_NOP;
        o_last_step = T2;
        case (i_op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                o_cls       = CLS_ALU_R;
                o_last_step = T5;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                o_cls       = CLS_ALU_I;
                o_last_step = T5;
            end
            OP_NEG, OP_NOT: begin
                o_cls       = CLS_UNARY;
                o_last_step = T4;
            end
            OP_LDI: begin
                o_cls       = CLS_LDI;
                o_last_step = T5;
            end
            OP_LD: begin
                o_cls       = CLS_LD;
                o_last_step = T7;
            end
            OP_ST: begin
                o_cls       = CLS_ST;
                o_last_step = T7;
            end
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV: begin
                o_cls       = CLS_MULDIV;
                o_last_step = T6;
            end
`endif
            OP_BR: begin
                o_cls       = CLS_BR;
                o_last_step = T6;
            end
            OP_JR: begin
                o_cls       = CLS_JR;
                o_last_step = T3;
            end
            OP_IN: begin
                o_cls       = CLS_IO_IN;
                o_last_step = T3;
            end
            OP_OUT: begin
                o_cls       = CLS_IO_OUT;
                o_last_step = T3;
            end
            OP_MFHI, OP_MFLO: begin
                o_cls       = CLS_MFX;
                o_last_step = T3;
            end
            OP_HALT: begin
                o_cls       = CLS_HALT;
                o_last_step = T2;
            end
            default: begin
                o_cls       = CLS_NOP;
                o_last_step = T2;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired control sequencer for the single-bus CPU. Steps the
//               fetch (T0-T2) and per-opcode execute steps (T3-T7) and drives
//               all datapath strobes as a Moore decode of state, step and the
//               IR opcode.
//   clk : system clock, rising edge
//   clr : asynchronous active-low reset
//   bus : control_unit_if.master - IR/CON_FF/Stop in, strobes/alu_op/Run out
// Build option: CTRL_MULDIV_EN - enables mul/div sequences (Zhighout, HIin).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic                r_stop_t2;

    logic [OP_W-1:0]     w_op;
    instr_class_t        w_cls;
    logic [STEP_W-1:0]   w_last;
    logic                w_fold;
    logic                w_fold_idle;
    strobes_t            w_s;
    logic [OP_W-1:0]     w_alu_op;
    logic                w_run;
`ifdef CTRL_MULDIV_EN
    logic                w_zhigh_out;
    logic                w_hi_in;
`endif

    assign w_op = bus.IR[31:27];

    ctrl_decode u_decode (
        .i_op        (w_op),
        .o_cls       (w_cls),
        .o_last_step (w_last)
    );

    // The opcode only becomes visible after IR loads at the end of T2, so
    // nop/halt cannot be recognised while T2 is running. Their "step 3" is
    // instead folded into whatever follows their T2: the next fetch T0, a
    // pause cycle (Stop seen in T2), or the first halted cycle. Externally
    // this makes nop exactly 3 cycles and halt stop after T2.
    assign w_fold      = (r_state == ST_RUN) && (r_step == T3) &&
                         ((w_cls == CLS_NOP) || (w_cls == CLS_HALT));
    assign w_fold_idle = w_fold && ((w_cls == CLS_HALT) || r_stop_t2);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= ST_RST;
            r_step    <= T0;
            r_stop_t2 <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state <= ST_RUN;
                    r_step  <= T0;
                end
                ST_RUN: begin
                    if (w_fold) begin
                        if (w_cls == CLS_HALT) begin
                            r_state <= ST_HALT;
                            r_step  <= T0;
                        end else if (r_stop_t2) begin
                            // This cycle served as the first pause cycle.
                            r_step  <= T0;
                            r_state <= bus.Stop ? ST_PAUSE : ST_RUN;
                        end else begin
                            // This cycle served as T0 of the next instruction.
                            r_step  <= T1;
                        end
                    end else if (r_step == T2) begin
                        r_stop_t2 <= bus.Stop;
                        r_step    <= T3;
                    end else if (r_step == w_last) begin
                        r_step <= T0;
                        if (bus.Stop) begin
                            r_state <= ST_PAUSE;
                        end
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.Stop) begin
                        r_state <= ST_RUN;
                        r_step  <= T0;
                    end
                end
                default: begin
                    // ST_HALT: left only through clr.
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    // Strobe decode. Combinational from the registered state/step so that the
    // outputs follow IR from T3 on and drop immediately when clr asserts.
    always_comb begin
        w_s      = '0;
        w_alu_op = OP_ADD;
        w_run    = 1'b0;
`ifdef CTRL_MULDIV_EN
        w_zhigh_out = 1'b0;
        w_hi_in     = 1'b0;
`endif
        if ((r_state == ST_RUN) && !w_fold_idle) begin
            w_run = 1'b1;
            if ((r_step == T0) || w_fold) begin
                w_s.pc_out = 1'b1;
                w_s.mar_in = 1'b1;
                w_s.inc_pc = 1'b1;
                w_s.z_in   = 1'b1;
            end else if (r_step == T1) begin
                w_s.zlow_out = 1'b1;
                w_s.pc_in    = 1'b1;
                w_s.read     = 1'b1;
                w_s.mdr_in   = 1'b1;
            end else if (r_step == T2) begin
                w_s.mdr_out = 1'b1;
                w_s.ir_in   = 1'b1;
            end else begin
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I: begin
                        case (r_step)
                            T3: begin
                                w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.y_in = 1'b1;
                            end
                            T4: begin
                                w_s.z_in = 1'b1;
                                w_alu_op = w_op;
                                if (w_cls == CLS_ALU_R) begin
                                    w_s.grc = 1'b1; w_s.r_out = 1'b1;
                                end else begin
                                    w_s.const_out = 1'b1;
                                end
                            end
                            T5: begin
                                w_s.zlow_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CLS_UNARY: begin
                        case (r_step)
                            T3: begin
                                w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.z_in = 1'b1;
                                w_alu_op = w_op;
                            end
                            T4: begin
                                w_s.zlow_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        // Shared effective-address computation Rb + C.
                        case (r_step)
                            T3: begin
                                w_s.grb = 1'b1; w_s.ba_out = 1'b1; w_s.y_in = 1'b1;
                            end
                            T4: begin
                                w_s.const_out = 1'b1; w_s.z_in = 1'b1;
                            end
                            T5: begin
                                w_s.zlow_out = 1'b1;
                                if (w_cls == CLS_LDI) begin
                                    w_s.gra = 1'b1; w_s.r_in = 1'b1;
                                end else begin
                                    w_s.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                w_s.mdr_in = 1'b1;
                                if (w_cls == CLS_LD) begin
                                    w_s.read = 1'b1;
                                end else begin
                                    w_s.gra = 1'b1; w_s.r_out = 1'b1;
                                end
                            end
                            T7: begin
                                if (w_cls == CLS_LD) begin
                                    w_s.mdr_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1;
                                end else begin
                                    w_s.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
`ifdef CTRL_MULDIV_EN
                    CLS_MULDIV: begin
                        case (r_step)
                            T3: begin
                                w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.y_in = 1'b1;
                            end
                            T4: begin
                                w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.z_in = 1'b1;
                                w_alu_op = w_op;
                            end
                            T5: begin
                                w_s.zlow_out = 1'b1; w_s.lo_in = 1'b1;
                            end
                            T6: begin
                                w_zhigh_out = 1'b1; w_hi_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
`endif
                    CLS_BR: begin
                        case (r_step)
                            T3: begin
                                w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.con_in = 1'b1;
                            end
                            T4: begin
                                w_s.pc_out = 1'b1; w_s.y_in = 1'b1;
                            end
                            T5: begin
                                w_s.const_out = 1'b1; w_s.z_in = 1'b1;
                            end
                            T6: begin
                                // Branch target is committed only when taken.
                                w_s.zlow_out = bus.CON_FF;
                                w_s.pc_in    = bus.CON_FF;
                            end
                            default: ;
                        endcase
                    end
                    CLS_JR: begin
                        w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.pc_in = 1'b1;
                    end
                    CLS_IO_IN: begin
                        w_s.inport_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1;
                    end
                    CLS_IO_OUT: begin
                        w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.outport_in = 1'b1;
                    end
                    CLS_MFX: begin
                        w_s.hi_out = (w_op == OP_MFHI);
                        w_s.lo_out = (w_op != OP_MFHI);
                        w_s.gra    = 1'b1;
                        w_s.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.PCout     = w_s.pc_out;
    assign bus.Zlowout   = w_s.zlow_out;
    assign bus.MDRout    = w_s.mdr_out;
    assign bus.HIout     = w_s.hi_out;
    assign bus.LOout     = w_s.lo_out;
    assign bus.InPortout = w_s.inport_out;
    assign bus.Cout      = w_s.const_out;
    assign bus.BAout     = w_s.ba_out;
    assign bus.Rout      = w_s.r_out;
    assign bus.PCin      = w_s.pc_in;
    assign bus.IRin      = w_s.ir_in;
    assign bus.MARin     = w_s.mar_in;
    assign bus.MDRin     = w_s.mdr_in;
    assign bus.Yin       = w_s.y_in;
    assign bus.Zin       = w_s.z_in;
    assign bus.LOin      = w_s.lo_in;
    assign bus.OutPortin = w_s.outport_in;
    assign bus.CONin     = w_s.con_in;
    assign bus.Rin       = w_s.r_in;
    assign bus.Gra       = w_s.gra;
    assign bus.Grb       = w_s.grb;
    assign bus.Grc       = w_s.grc;
    assign bus.IncPC     = w_s.inc_pc;
    assign bus.Read      = w_s.read;
    assign bus.Write     = w_s.write;
    assign bus.alu_op    = w_alu_op;
    assign bus.Run       = w_run;
`ifdef CTRL_MULDIV_EN
    assign bus.Zhighout  = w_zhigh_out;
    assign bus.HIin      = w_hi_in;
`else
    assign bus.Zhighout  = 1'b0;
    assign bus.HIin      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the single-bus CPU. It steps fetch (T0–T2) and per-opcode execute steps (T3–T7), and drives every datapath strobe that the datapath testbenches currently hand-drive. Register selection is emitted as Gra/Grb/Grc/Rin/Rout/BAout for the select-and-encode logic. It sits directly upstream of `datapath` and reads IR and CON_FF back from it.

## Interface
- STEP_W, 3, step counter width (T0–T7)
- OP_W, 5, opcode width, IR[31:27]
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-low reset
- IR  in  32  instruction register; opcode IR[31:27]
- CON_FF  in  1  branch condition flag from datapath
- Stop  in  1  pause request, honoured at instruction boundary
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus drive strobes
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin  out  1 each  register load strobes
- Gra, Grb, Grc  out  1 each  select Ra / Rb / Rc field for Rin/Rout/BAout
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
- alu_op  out  OP_W  ALU function, opcode encoding
- Run  out  1  high while executing, low when paused or halted

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011.
- Undefined opcodes (10100, 11100–11111) execute as nop.
- States: RST, RUN (step 0–7), PAUSE, HALT. Outputs are a Moore decode of state, step and the latched IR opcode.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute:
  - Reg ALU ops: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=op; T5 Zlowout Gra Rin.
  - addi/andi/ori: same, with Cout replacing Grc Rout at T4.
  - neg/not: T3 Grb Rout Zin alu_op=op; T4 Zlowout Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 Cout Zin alu_op=add; T5 Zlowout Gra Rin.
  - ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin with Read=0; T7 Write.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin alu_op=op; T5 Zlowout LOin; T6 Zhighout HIin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin alu_op=add; T6 Zlowout PCin only if CON_FF=1.
  - jr: T3 Gra Rout PCin.
  - in / out / mfhi / mflo: T3 InPortout / Gra Rout OutPortin / HIout / LOout, with Gra Rin where a register is written.
  - nop: last step T2.
- After the opcode's last step: if Stop=1 go to PAUSE, else go to step 0.
- PAUSE: no strobes, Run=0; returns to step 0 on the first cycle Stop=0.
- halt: enters HALT after T2. HALT drives no strobes, Run=0, and is left only by reset.
- alu_op = add (00011) whenever not otherwise specified.

## Timing
- clr low, asynchronously: state=RST, step=0, all strobes 0, alu_op=00011, Run=0.
- First rising edge with clr high: RST→RUN step 0, Run=1.
- Each step occupies exactly one clk cycle. Strobes are valid for the whole cycle and are captured by the datapath on the closing edge.
- Cycle counts: nop 3, jr/in/out/mfhi/mflo 4, neg/not 5, ALU/imm/ldi 6, mul/div and br 7, ld/st 8.
- IR is sampled combinationally from step 3 on. IR loads at the end of T2, so T2 decode never uses the new IR.
- CON_FF is sampled only in br T6.
- Stop is sampled only on a last-step cycle; Stop pulses at other times are ignored.
- clr low mid-instruction aborts the instruction immediately with no partial strobes.

## Configuration
- CTRL_MULDIV_EN defined: mul/div sequences as above; HIin and Zhighout are driven.
- CTRL_MULDIV_EN undefined: opcodes 01111/10000 execute as nop; HIin and Zhighout are tied 0.

## Structure
- `cpu_pkg` holds:
  - opcode localparams, also used as alu_op codes;
  - state encoding (RST, RUN, PAUSE, HALT);
  - step constants T0–T7.
- Sub-module `ctrl_decode` (combinational): maps opcode to instruction class (ALU_R, ALU_I, UNARY, LD, LDI, ST, MULDIV, BR, JR, IO_IN, IO_OUT, MFX, NOP, HALT) and a last-step index.
- Top level holds the state/step registers and the strobe decode.

## Test plan
- Reset with clr low, then release: all strobes 0 during reset; first cycle after release shows PCout=MARin=IncPC=Zin=1 with Run=1.
- IR=0x28918000 (shr R1,R2,R3): T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=00101; T5 Zlowout Gra Rin; next cycle is T0.
- ld (IR=0x00800005): Read=MDRin=1 in T1 and T6; MDRout Gra Rin in T7; instruction takes 8 cycles.
- br with CON_FF=0 then CON_FF=1: PCin=0 in T6 for the first; Zlowout=PCin=1 in T6 for the second.
- Stop=1 asserted mid-add: add completes, PAUSE follows with Run=0 and no strobes; Stop=0 resumes at T0.
- halt opcode 11011 followed by further clocks: Run=0 and no strobes indefinitely; clr pulse restarts at T0.
